// File: rtl/vga_scan_out.sv
// 640x480@60 VGA scan generator and blanked colour output stage.
// Addresses the framebuffer front half and pulses frame_start on wrap.
module vga_scan_out #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  input  logic [11:0] color_in,
  output logic        pixel_en,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          hs_zone;
  logic          vs_zone;

  assign h_last  = (hc == H_LAST);
  assign v_last  = (vc == V_LAST);
  assign active  = (hc < H_VIS) && (vc < V_VIS);
  assign hs_zone = (hc >= HS_LO) && (hc <= HS_HI);
  assign vs_zone = (vc >= VS_LO) && (vc <= VS_HI);

  // pixel_en is registered, so it is set one clock before div hits its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      pixel_en <= 1'b0;
    end else begin
      div      <= (div == DIV_LAST) ? '0 : div + DW'(1);
      pixel_en <= (div == DIV_PRE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pixel_en && h_last && v_last;
      if (pixel_en) begin
        hc <= h_last ? '0 : hc + 10'd1;
        if (h_last) begin
          vc <= v_last ? '0 : vc + 10'd1;
        end
      end
    end
  end

  // Decoded from pre-increment position, so these lag hc/vc by one pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (pixel_en) begin
      hsync <= !hs_zone;
      vsync <= !vs_zone;
      vga_r <= active ? color_in[11:8] : 4'h0;
      vga_g <= active ? color_in[7:4]  : 4'h0;
      vga_b <= active ? color_in[3:0]  : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out on a reduced raster.
// Timing model is derived from clocks elapsed since reset release.
module tb_vga_scan_out;

  localparam int HV = 20;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 5;
  localparam int VV = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int CD = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [11:0] color_in;
  logic        pixel_en;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  vga_scan_out #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hc(hc),
    .vc(vc),
    .color_in(color_in),
    .pixel_en(pixel_en),
    .frame_start(frame_start),
    .hsync(hsync),
    .vsync(vsync),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   t;
  int   mode;
  int   fs_seen;
  exp_t sb[$];
  exp_t cur;
  exp_t rst_exp;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h t=%0d", tag, got, want, t);
    end
  endtask

  task automatic chk_reset();
    chk("rst_hc", int'(hc), 0);
    chk("rst_vc", int'(vc), 0);
    chk("rst_pe", int'(pixel_en), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_hs", int'(hsync), 1);
    chk("rst_vs", int'(vsync), 1);
    chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
  endtask

  // Present colour for the position now on hc/vc and queue its output
  task automatic drive();
    int   n;
    int   h;
    int   v;
    exp_t e;
    n = t / CD;
    h = n % HT;
    v = (n / HT) % VT;
    if (mode == 1) color_in = 12'hFFF;
    else if (h == 5 && v == 3) color_in = 12'hA5C;
    else color_in = 12'($urandom);
    e.rgb = (h < HV && v < VV) ? color_in : 12'h000;
    e.hs  = !(h >= HV + HF && h < HV + HF + HS);
    e.vs  = !(v >= VV + VF && v < VV + VF + VS);
    sb.push_back(e);
  endtask

  task automatic tick();
    int n;
    int fs;
    @(posedge clk);
    t++;
    @(negedge clk);
    n  = t / CD;
    fs = (t % CD == 0 && n > 0 && n % FRAME == 0) ? 1 : 0;
    chk("hc", int'(hc), n % HT);
    chk("vc", int'(vc), (n / HT) % VT);
    chk("pixel_en", int'(pixel_en), (t % CD == CD - 1) ? 1 : 0);
    chk("frame_start", int'(frame_start), fs);
    if (frame_start) fs_seen++;
    if (t % CD == 0) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        cur = sb.pop_front();
      end
    end
    chk("rgb", int'({vga_r, vga_g, vga_b}), int'(cur.rgb));
    chk("hsync", int'(hsync), int'(cur.hs));
    chk("vsync", int'(vsync), int'(cur.vs));
    if (t % CD == 0) drive();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    t   = 0;
    cur = rst_exp;
    sb.delete();
    drive();
  endtask

  initial begin
    rst_exp  = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
    rst      = 1'b1;
    color_in = 12'h000;
    mode     = 0;
    fs_seen  = 0;
    t        = 0;
    repeat (3) @(negedge clk);
    chk_reset();

    release_rst();
    while (t < CD * FRAME + 40) tick();
    chk("fs_count", fs_seen, 1);

    mode = 1;
    while (t < 2 * CD * FRAME + 80) tick();

    mode = 0;
    for (int i = 0; i < CD * FRAME + 4; i++) begin
      if (t % CD == 0 && (t / CD) % FRAME == 7 * HT + 13) break;
      tick();
    end
    chk("rst_point_hc", int'(hc), 13);
    chk("rst_point_vc", int'(vc), 7);

    rst = 1'b1;
    #1;
    chk_reset();
    repeat (2) begin
      @(negedge clk);
      chk_reset();
    end

    fs_seen = 0;
    release_rst();
    while (t < CD * FRAME - 8) tick();
    chk("no_spurious_fs", fs_seen, 0);
    while (t < CD * FRAME + 8) tick();
    chk("fs_after_rst", fs_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Display-side reader for the 32x24-block double-buffered framebuffer.
- Generates the 640x480@60 scan position hc/vc that addresses the buffer's front half.
- Samples the 12-bit colour the buffer returns and drives VGA RGB and sync pins with blanking applied.
- Sits between the framebuffer and the board VGA connector; also emits a frame_start pulse for the renderer that fills the back half.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- hc  out  10  horizontal pixel counter, 0..H_TOTAL-1; drives buffer hc
- vc  out  10  vertical line counter, 0..V_TOTAL-1; drives buffer vc
- color_in  in  12  colour from buffer colorOut, {R[11:8],G[7:4],B[3:0]}; registered there, valid 1 clk after hc/vc change
- pixel_en  out  1  one-clk strobe, once per CLK_DIV clocks
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue

Behaviour:
- Derived totals: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Reset (async, immediate): div counter=0, hc=0, vc=0, pixel_en=0, frame_start=0, hsync=1, vsync=1, RGB=0.
- Clock divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_en is registered, high exactly on the clk where the divider equals CLK_DIV-1.
  - First pixel_en after reset release occurs at clk CLK_DIV-1.
- Counters advance only on pixel_en clocks:
  - hc increments; at hc=H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc=V_TOTAL-1 with hc wrap, vc wraps to 0.
  - hc/vc hold for exactly CLK_DIV clocks between changes.
- Output stage, updated on the same pixel_en clocks and decoded from pre-increment hc/vc:
  - active = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - RGB <= active ? color_in split into nibbles : 0.
  - hsync <= !(hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for 656..751.
  - vsync <= !(vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for lines 490..491.
  - RGB, hsync and vsync therefore lag hc/vc by exactly one pixel period; all are mutually aligned.
- Buffer latency: color_in is sampled CLK_DIV clocks after the address was presented; the CLK_DIV >= 2 rule guarantees the buffer's 1-clk read has settled.
- frame_start:
  - Registered, high for one clk on the pixel_en clock that moves (hc,vc) from (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - Not asserted for the reset-entry (0,0) state.
- Reset mid-frame: all state returns to reset values immediately; scanning restarts from (0,0) with no partial pulse generation.
- Widths: counters are 10 bits; H_TOTAL and V_TOTAL must be <= 1024. No other arithmetic overflow is possible.

Test Plan:
- Reset release -> pixel_en high at clks 3, 7, 11, ...; hc reads 1 at clk 4; all outputs at reset values before the first pixel_en.
- Run one line -> hsync low for 96 pixel periods (384 clks), falling edge one pixel period after hc reaches 656; hc wraps 799->0 and vc increments at the same clk.
- Run one full frame -> vsync low for exactly 2 lines (1600 pixel periods) starting one pixel after (0,490); frame_start pulses once per 1,680,000 clks.
- Drive color_in = 12'hA5C for hc=5, vc=3 -> vga_r=A, vga_g=5, vga_b=C appear one pixel period after hc=5 is presented.
- Drive color_in=12'hFFF constantly -> RGB stays 0 whenever the lagged position is hc>=640 or vc>=480; F otherwise.
- Assert rst at hc=300, vc=200 for 2 clks -> outputs return to reset values asynchronously; after release, timing is identical to the first scenario and there is no spurious frame_start.
